// File: rtl/ex_pkg.sv
// Shared encodings for the execute operand stage: ALU control codes,
// RISC-V base opcodes, operand-select codes and the held-instruction slot.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0010,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SLTU = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLL  = 4'b1100,
    ALU_SRL  = 4'b1101,
    ALU_SRA  = 4'b1110
  } alu_ctl_e;

  typedef enum logic [1:0] {
    DA_RS1  = 2'd0,
    DA_ZERO = 2'd1,
    DA_PC   = 2'd2
  } da_sel_e;

  typedef enum logic [1:0] {
    DB_RS2  = 2'd0,
    DB_IMM  = 2'd1,
    DB_FOUR = 2'd2
  } db_sel_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
  } slot_t;

endpackage

// File: rtl/ex_alu_dec.sv
// Combinational decode of opcode/funct fields into ALU control, operand
// selects, register-write enable, illegal flag and source-register usage.
module ex_alu_dec
  import ex_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic [4:0] rd,
  output logic [3:0] alu_ctl,
  output da_sel_e    da_sel,
  output db_sel_e    db_sel,
  output logic       wen,
  output logic       illegal,
  output logic       rs1_used,
  output logic       rs2_used
);

  // SUB exists only in register form; the alt bit always selects SRA vs SRL.
  function automatic alu_ctl_e arith_ctl(input logic [2:0] f3, input logic alt,
                                         input logic is_reg);
    alu_ctl_e c;
    case (f3)
      3'b000:  c = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  alu_ctl_e ctl;
  logic     rd_nz;

  assign rd_nz   = (rd != '0);
  assign alu_ctl = ctl;

  always_comb begin
    ctl      = ALU_ADD;
    da_sel   = DA_RS1;
    db_sel   = DB_RS2;
    wen      = 1'b0;
    illegal  = 1'b0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctl      = arith_ctl(funct3, funct7_5, 1'b1);
        rs2_used = 1'b1;
        wen      = rd_nz;
      end
      OPC_OP_IMM: begin
        ctl    = arith_ctl(funct3, funct7_5, 1'b0);
        db_sel = DB_IMM;
        wen    = rd_nz;
      end
      OPC_LUI: begin
        da_sel   = DA_ZERO;
        db_sel   = DB_IMM;
        rs1_used = 1'b0;
        wen      = rd_nz;
      end
      OPC_AUIPC: begin
        da_sel   = DA_PC;
        db_sel   = DB_IMM;
        rs1_used = 1'b0;
        wen      = rd_nz;
      end
      OPC_JAL: begin
        da_sel   = DA_PC;
        db_sel   = DB_FOUR;
        rs1_used = 1'b0;
        wen      = rd_nz;
      end
      OPC_JALR: begin
        da_sel = DA_PC;
        db_sel = DB_FOUR;
        wen    = rd_nz;
      end
      OPC_LOAD: begin
        db_sel = DB_IMM;
        wen    = rd_nz;
      end
      OPC_STORE: begin
        db_sel   = DB_IMM;
        rs2_used = 1'b1;
      end
      OPC_BRANCH: begin
        rs2_used = 1'b1;
        case (funct3[2:1])
          2'b10:   ctl = ALU_SLT;
          2'b11:   ctl = ALU_SLTU;
          default: ctl = ALU_SUB;
        endcase
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Single-slot operand stage between decode and the ALU: holds one
// instruction, detects load-use hazards, forwards MEM/WB results.
module ex_operand_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [6:0]  id_opcode,
  input  logic [2:0]  id_funct3,
  input  logic        id_funct7_5,
  input  logic        flush,
  input  logic        mem_wen,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        mem_is_load,
  input  logic        wb_wen,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] alu_da,
  output logic [31:0] alu_db,
  output logic [3:0]  alu_ctl,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rd,
  output logic        ex_wen,
  output logic [31:0] ex_store_data,
  output logic        ex_illegal,
  output logic [2:0]  ex_br_funct3
);

  logic        v_q;
  slot_t       slot_q;
  slot_t       slot_d;
  logic        capture;
  logic        hazard;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;

  logic [3:0]  dec_ctl;
  da_sel_e     dec_da_sel;
  db_sel_e     dec_db_sel;
  logic        dec_wen;
  logic        dec_illegal;
  logic        rs1_used;
  logic        rs2_used;

  assign slot_d = '{pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
                    imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    opcode: id_opcode, funct3: id_funct3, funct7_5: id_funct7_5};

  ex_alu_dec u_dec (
    .opcode   (slot_q.opcode),
    .funct3   (slot_q.funct3),
    .funct7_5 (slot_q.funct7_5),
    .rd       (slot_q.rd),
    .alu_ctl  (dec_ctl),
    .da_sel   (dec_da_sel),
    .db_sel   (dec_db_sel),
    .wen      (dec_wen),
    .illegal  (dec_illegal),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign hazard = v_q & mem_is_load & mem_wen & (mem_rd != '0) &
                  ((rs1_used & (slot_q.rs1 == mem_rd)) |
                   (rs2_used & (slot_q.rs2 == mem_rd)));

  assign ex_valid = v_q & ~hazard;
  assign id_ready = ~v_q | (ex_ready & ~hazard);
  assign capture  = id_valid & id_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      slot_q <= '0;
    end else begin
      if (flush)
        v_q <= 1'b0;
      else if (capture)
        v_q <= 1'b1;
      else if (ex_valid && ex_ready)
        v_q <= 1'b0;
      if (capture)
        slot_q <= slot_d;
    end
  end

  // A load in MEM has no data yet, so it is skipped and WB may still supply
  // an older value; the hazard logic stalls whenever that matters.
  always_comb begin
    rs1_fwd = slot_q.rs1_data;
    if (mem_wen && !mem_is_load && (mem_rd != '0) && (mem_rd == slot_q.rs1))
      rs1_fwd = mem_data;
    else if (wb_wen && (wb_rd != '0) && (wb_rd == slot_q.rs1))
      rs1_fwd = wb_data;

    rs2_fwd = slot_q.rs2_data;
    if (mem_wen && !mem_is_load && (mem_rd != '0) && (mem_rd == slot_q.rs2))
      rs2_fwd = mem_data;
    else if (wb_wen && (wb_rd != '0) && (wb_rd == slot_q.rs2))
      rs2_fwd = wb_data;
  end

  always_comb begin
    case (dec_da_sel)
      DA_ZERO: alu_da = '0;
      DA_PC:   alu_da = slot_q.pc;
      default: alu_da = rs1_fwd;
    endcase
    case (dec_db_sel)
      DB_IMM:  alu_db = slot_q.imm;
      DB_FOUR: alu_db = 32'd4;
      default: alu_db = rs2_fwd;
    endcase
  end

  assign alu_ctl       = dec_ctl;
  assign ex_pc         = slot_q.pc;
  assign ex_rd         = slot_q.rd;
  assign ex_wen        = v_q & dec_wen;
  assign ex_store_data = rs2_fwd;
  assign ex_illegal    = v_q & dec_illegal;
  assign ex_br_funct3  = slot_q.funct3;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: expected results are queued at issue
// time and compared when the stage presents the instruction.
module tb_ex_operand_stage;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] STORE  = 7'b0100011;

  logic        clk, rst;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7_5, flush;
  logic        mem_wen, mem_is_load, wb_wen;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_da, alu_db, ex_pc, ex_store_data;
  logic [3:0]  alu_ctl;
  logic [4:0]  ex_rd;
  logic        ex_wen, ex_illegal;
  logic [2:0]  ex_br_funct3;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .flush(flush), .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_is_load(mem_is_load), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_da(alu_da), .alu_db(alu_db),
    .alu_ctl(alu_ctl), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_store_data(ex_store_data), .ex_illegal(ex_illegal),
    .ex_br_funct3(ex_br_funct3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] da, db, pc, sd;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic        wen, ill;
    logic [2:0]  f3;
    bit          ops;
  } exp_t;

  exp_t sb[$];
  int unsigned vectors = 0;
  int unsigned fails   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] da, input logic [31:0] db,
                              input logic [3:0] ctl, input logic [4:0] rd,
                              input logic wen, input logic ill, input logic [2:0] f3,
                              input logic [31:0] pc, input logic [31:0] sd, input bit ops);
    exp_t e;
    e.da = da; e.db = db; e.ctl = ctl; e.rd = rd; e.wen = wen; e.ill = ill;
    e.f3 = f3; e.pc = pc; e.sd = sd; e.ops = ops;
    return e;
  endfunction

  task automatic set_id(input logic [31:0] pc, input logic [31:0] rs1d,
                        input logic [31:0] rs2d, input logic [31:0] imm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    id_pc = pc; id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_opcode = opc; id_funct3 = f3; id_funct7_5 = f7;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] rs1d,
                       input logic [31:0] rs2d, input logic [31:0] imm,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    set_id(pc, rs1d, rs2d, imm, rs1, rs2, rd, opc, f3, f7);
    id_valid = 1'b1;
    #1;
    chk("id_ready_at_issue", 32'(id_ready), 32'd1);
    @(posedge clk); #1;
    id_valid = 1'b0;
  endtask

  task automatic wait_valid(input int unsigned budget);
    int unsigned n = 0;
    #1;
    while (!ex_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    vectors++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s_sb_underflow observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(ex_valid), 32'd1);
      if (e.ops) begin
        chk({tag, "_da"}, alu_da, e.da);
        chk({tag, "_db"}, alu_db, e.db);
        chk({tag, "_sd"}, ex_store_data, e.sd);
      end
      chk({tag, "_ctl"}, 32'(alu_ctl), 32'(e.ctl));
      chk({tag, "_rd"}, 32'(ex_rd), 32'(e.rd));
      chk({tag, "_wen"}, 32'(ex_wen), 32'(e.wen));
      chk({tag, "_ill"}, 32'(ex_illegal), 32'(e.ill));
      chk({tag, "_f3"}, 32'(ex_br_funct3), 32'(e.f3));
      chk({tag, "_pc"}, ex_pc, e.pc);
    end
  endtask

  task automatic clear_fwd;
    mem_wen = 1'b0; mem_is_load = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    wb_wen = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b0;
    clear_fwd();
    set_id(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 7'd0, 3'd0, 1'b0);

    // Reset with a competing capture request: reset wins.
    @(posedge clk); #1;
    set_id(32'h50, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3, OP, 3'd0, 1'b0);
    id_valid = 1'b1;
    @(posedge clk); #1;
    id_valid = 1'b0;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_illegal", 32'(ex_illegal), 32'd0);
    chk("rst_alu_ctl", 32'(alu_ctl), 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd1);
    rst = 1'b0;

    // ADD x3,x1,x2
    sb.push_back(mk(32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0, 3'd0, 32'h100, 32'd7, 1'b1));
    issue(32'h100, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, OP, 3'd0, 1'b0);
    check_pop("add");
    @(posedge clk); #1;
    chk("drain_ex_valid", 32'(ex_valid), 32'd0);

    // SUB x4,x1,x1: MEM beats WB, then WB, then register data.
    ex_ready = 1'b0;
    mem_wen = 1'b1; mem_rd = 5'd1; mem_data = 32'h10;
    wb_wen = 1'b1; wb_rd = 5'd1; wb_data = 32'h20;
    sb.push_back(mk(32'h10, 32'h10, 4'b0010, 5'd4, 1'b1, 1'b0, 3'd0, 32'h104, 32'h10, 1'b1));
    issue(32'h104, 32'h99, 32'h99, 32'd0, 5'd1, 5'd1, 5'd4, OP, 3'd0, 1'b1);
    check_pop("sub_mem_fwd");
    mem_wen = 1'b0; #1;
    chk("sub_wb_fwd_da", alu_da, 32'h20);
    chk("sub_wb_fwd_db", alu_db, 32'h20);
    wb_wen = 1'b0; #1;
    chk("sub_rf_da", alu_da, 32'h99);
    ex_ready = 1'b1;
    @(posedge clk); #1;

    // Load-use: OR x5,x2,x6 stalls behind a load to x2.
    mem_wen = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd2; mem_data = 32'h55;
    wb_wen = 1'b1; wb_rd = 5'd2; wb_data = 32'hAB;
    sb.push_back(mk(32'hAB, 32'h22, 4'b0101, 5'd5, 1'b1, 1'b0, 3'd6, 32'h108, 32'h22, 1'b1));
    issue(32'h108, 32'h11, 32'h22, 32'd0, 5'd2, 5'd6, 5'd5, OP, 3'd6, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("hazard_ex_valid", 32'(ex_valid), 32'd0);
      chk("hazard_id_ready", 32'(id_ready), 32'd0);
      @(posedge clk); #1;
    end
    mem_is_load = 1'b0; mem_wen = 1'b0;
    wait_valid(4);
    check_pop("load_use");
    @(posedge clk); #1;
    clear_fwd();

    // SRAI x7,x8,3; a load to x3 matches only the unused rs2 field.
    mem_wen = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd3;
    sb.push_back(mk(32'h80000000, 32'd3, 4'b1110, 5'd7, 1'b1, 1'b0, 3'd5, 32'h10C, 32'h1234, 1'b1));
    issue(32'h10C, 32'h80000000, 32'h1234, 32'd3, 5'd8, 5'd3, 5'd7, OPIMM, 3'd5, 1'b1);
    check_pop("srai");
    @(posedge clk); #1;
    clear_fwd();

    // ADDI with funct7_5 set never subtracts.
    sb.push_back(mk(32'h40, 32'd5, 4'b0000, 5'd1, 1'b1, 1'b0, 3'd0, 32'h110, 32'd0, 1'b1));
    issue(32'h110, 32'h40, 32'd0, 32'd5, 5'd2, 5'd0, 5'd1, OPIMM, 3'd0, 1'b1);
    check_pop("addi_f7");
    @(posedge clk); #1;

    // XOR stalled 3 cycles with a new instruction pending, then flushed.
    ex_ready = 1'b0;
    sb.push_back(mk(32'hF0, 32'h0F, 4'b0110, 5'd9, 1'b1, 1'b0, 3'd4, 32'h114, 32'h0F, 1'b1));
    issue(32'h114, 32'hF0, 32'h0F, 32'd0, 5'd10, 5'd11, 5'd9, OP, 3'd4, 1'b0);
    check_pop("xor");
    set_id(32'h118, 32'h1, 32'h2, 32'd0, 5'd12, 5'd13, 5'd14, OP, 3'd7, 1'b0);
    id_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_id_ready", 32'(id_ready), 32'd0);
      chk("stall_ex_valid", 32'(ex_valid), 32'd1);
      chk("stall_da", alu_da, 32'hF0);
      chk("stall_ctl", 32'(alu_ctl), 32'd6);
      chk("stall_pc", ex_pc, 32'h114);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    id_valid = 1'b0;
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    @(posedge clk); #1;
    chk("flush_no_capture_valid", 32'(ex_valid), 32'd0);
    chk("flush_no_capture_pc", ex_pc, 32'h114);
    ex_ready = 1'b1;

    // BLTU, illegal opcode, SW, LUI, JAL with rd=1 and rd=0, back to back.
    sb.push_back(mk(32'd1, 32'd2, 4'b1000, 5'd10, 1'b0, 1'b0, 3'd6, 32'h11C, 32'd2, 1'b1));
    issue(32'h11C, 32'd1, 32'd2, 32'h10, 5'd1, 5'd2, 5'd10, BRANCH, 3'd6, 1'b0);
    check_pop("bltu");
    sb.push_back(mk(32'd0, 32'd0, 4'b0000, 5'd5, 1'b0, 1'b1, 3'd0, 32'h120, 32'd0, 1'b0));
    issue(32'h120, 32'h77, 32'h33, 32'd0, 5'd1, 5'd2, 5'd5, 7'b1111111, 3'd0, 1'b0);
    check_pop("illegal");
    sb.push_back(mk(32'h100, 32'd8, 4'b0000, 5'd8, 1'b0, 1'b0, 3'd2, 32'h124, 32'hDEAD, 1'b1));
    issue(32'h124, 32'h100, 32'hDEAD, 32'd8, 5'd3, 5'd4, 5'd8, STORE, 3'd2, 1'b0);
    check_pop("sw");
    sb.push_back(mk(32'd0, 32'h12345000, 4'b0000, 5'd6, 1'b1, 1'b0, 3'd0, 32'h128, 32'd0, 1'b1));
    issue(32'h128, 32'h999, 32'd0, 32'h12345000, 5'd5, 5'd0, 5'd6, LUI, 3'd0, 1'b0);
    check_pop("lui");
    sb.push_back(mk(32'h12C, 32'd4, 4'b0000, 5'd1, 1'b1, 1'b0, 3'd0, 32'h12C, 32'd0, 1'b1));
    issue(32'h12C, 32'h5, 32'd0, 32'h800, 5'd0, 5'd0, 5'd1, JAL, 3'd0, 1'b0);
    check_pop("jal_rd1");
    sb.push_back(mk(32'h130, 32'd4, 4'b0000, 5'd0, 1'b0, 1'b0, 3'd0, 32'h130, 32'd0, 1'b1));
    issue(32'h130, 32'h5, 32'd0, 32'h800, 5'd0, 5'd0, 5'd0, JAL, 3'd0, 1'b0);
    check_pop("jal_rd0");
    @(posedge clk); #1;
    chk("drain2_ex_valid", 32'(ex_valid), 32'd0);

    // Reset while held in a load-use hazard.
    mem_wen = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd1;
    issue(32'h134, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3, OP, 3'd0, 1'b0);
    chk("pre_rst_hazard", 32'(ex_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_fwd();
    #1;
    chk("post_rst_id_ready", 32'(id_ready), 32'd1);
    chk("post_rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("post_rst_alu_ctl", 32'(alu_ctl), 32'd0);
    chk("post_rst_illegal", 32'(ex_illegal), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports id_valid in 1 and id_ready out 1: decode-to-stage handshake.
REQ-004 SHALL have inputs id_pc, id_rs1_data, id_rs2_data, id_imm (32 each) and id_rs1, id_rs2, id_rd (5 each).
REQ-005 SHALL have inputs id_opcode (7), id_funct3 (3) and id_funct7_5 (1), which is instruction bit 30.
REQ-006 SHALL have input flush (1), which kills the held instruction.
REQ-007 SHALL have forwarding inputs mem_wen (1), mem_rd (5), mem_data (32), mem_is_load (1), wb_wen (1), wb_rd (5) and wb_data (32).
REQ-008 SHALL have output ex_valid (1) and input ex_ready (1): stage-to-ALU/EX-MEM handshake.
REQ-009 SHALL have outputs alu_da (32), alu_db (32) and alu_ctl (4), which drive the ALU directly.
REQ-010 SHALL have outputs ex_pc (32), ex_rd (5), ex_wen (1), ex_store_data (32), ex_illegal (1) and ex_br_funct3 (3).

Function
REQ-011 SHALL hold one registered instruction slot, v_q, with a one-cycle latency from an id handshake to ex_valid.
REQ-012 SHALL drive id_ready = ~v_q | (ex_ready & ~hazard).
- Capture occurs on id_valid & id_ready.
- If v_q is set and no capture occurs, the slot empties on ex_valid & ex_ready.
REQ-013 SHALL assert hazard = v_q & mem_is_load & mem_wen & (mem_rd != 0) & (mem_rd equals a used rs1 or rs2).
- While hazard is high: ex_valid = 0, the slot holds and nothing is captured.
REQ-014 SHALL drive ex_valid = v_q & ~hazard.
REQ-015 SHALL, when flush is high, clear v_q next cycle and capture nothing, even if id_valid is high; flush overrides both capture and hold.
REQ-016 SHALL resolve operands combinationally from the registered rs1/rs2 fields in this order:
- MEM (mem_wen, rd match, not a load);
- then WB (wb_wen, rd match);
- then the registered register-file data.
- rd == 0 is never forwarded.
REQ-017 SHALL decode alu_ctl with these encodings: ADD 0000, SUB 0010, AND 0100, OR 0101, XOR 0110, SLTU 1000, SLT 1001, SLL 1100, SRL 1101, SRA 1110.
REQ-018 SHALL decode OP (0110011) with alu_da = rs1 and alu_db = rs2.
- funct7_5 selects SUB over ADD and SRA over SRL.
- ex_wen = (rd != 0).
REQ-019 SHALL decode OP-IMM (0010011) with alu_db = imm.
- funct7_5 is honoured only for SRAI; ADDI never subtracts.
REQ-020 SHALL decode the following opcodes as ADD:
- LUI: da = 0, db = imm.
- AUIPC: da = pc, db = imm.
- JAL/JALR: da = pc, db = 4; ex_wen = (rd != 0).
REQ-021 SHALL decode LOAD and STORE as ADD with da = rs1 and db = imm.
- STORE: ex_store_data = forwarded rs2, ex_wen = 0.
REQ-022 SHALL decode BRANCH with da = rs1, db = rs2 and ex_wen = 0.
- BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
- ex_br_funct3 = funct3.
REQ-023 SHALL treat any other opcode as illegal: ex_illegal = 1, alu_ctl = 0000, ex_wen = 0, ex_valid still asserted.
REQ-024 SHALL treat rs2 as "used" only for OP, STORE and BRANCH, and rs1 as unused for LUI, AUIPC and JAL.
REQ-025 SHALL keep all outputs stable while ex_valid & ~ex_ready.

Reset
REQ-026 SHALL, on rst at a clock edge, clear v_q and all registered fields to 0, so that ex_valid = 0, ex_illegal = 0 and alu_ctl = 0000.
REQ-027 SHALL, when rst is asserted mid-stall or mid-hazard, discard the held instruction; id_ready = 1 on the first cycle after rst falls.
REQ-028 SHALL give rst priority over flush and capture.

Structure
REQ-029 SHALL take the ALU_CTL encodings, RISC-V opcode constants and operand-select encodings from the shared package ex_pkg.
REQ-030 SHALL place the opcode/funct-to-{alu_ctl, da_sel, db_sel, wen, illegal, rs_used} decode in the purely combinational sub-module ex_alu_dec; the top holds the slot, hazard logic and forwarding.

Verification
REQ-031 SHALL pass: ADD x3,x1,x2 with rs1 = 5 and rs2 = 7 -> one cycle later ex_valid = 1, da = 5, db = 7, alu_ctl = 0000, ex_rd = 3, ex_wen = 1.
REQ-032 SHALL pass: SUB x4,x1,x1 held with mem_wen = 1, mem_rd = 1, mem_data = 0x10, wb_rd = 1, wb_data = 0x20 -> da = db = 0x10, alu_ctl = 0010.
REQ-033 SHALL pass: load-use case, with OR x5,x2,x6 held and mem_is_load = 1, mem_rd = 2 -> ex_valid = 0 and id_ready = 0 until mem_is_load drops, then ex_valid = 1 with WB data 0xAB forwarded.
REQ-034 SHALL pass: SRAI x7,x8,3 (funct7_5 = 1) -> alu_ctl = 1110, db = 3; ADDI with funct7_5 = 1 -> alu_ctl = 0000.
REQ-035 SHALL pass: ex_ready = 0 for 3 cycles with a new id_valid pending -> outputs unchanged, id_ready = 0; flush during the stall -> ex_valid = 0 next cycle and the pending instruction is not captured.
REQ-036 SHALL pass: BLTU with rs1 = 1, rs2 = 2 -> alu_ctl = 1000, ex_wen = 0, ex_br_funct3 = 110; opcode 1111111 -> ex_illegal = 1, ex_wen = 0.
